// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, nibble order and fb_fill state encoding shared with the video block.
package fb_pkg;
    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 400;
    localparam int STRIDE  = 320;
    localparam int ADDR_W  = 18;
    localparam int COORD_W = 10;
    localparam int BX_W    = 9;
    // Even pixel lives in the high nibble of each byte.
    localparam bit EVEN_HI = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SPAN, S_READ, S_MERGE, S_DONE} fb_state_t;
endpackage

// File: rtl/fb_fill_if.sv
// fb_fill_if: command handshake and framebuffer write-port bundle for fb_fill.
interface fb_fill_if;
    import fb_pkg::*;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_y1;
    logic [3:0]         cmd_color;
    logic [ADDR_W-1:0]  mem_address;
    logic [7:0]         mem_wdata;
    logic               mem_we;
    logic [7:0]         mem_rdata;
    logic               busy;
    logic               done;
    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, mem_rdata,
        input  cmd_ready, mem_address, mem_wdata, mem_we, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, mem_rdata,
        output cmd_ready, mem_address, mem_wdata, mem_we, busy, done
    );
endinterface

// File: rtl/fb_nibble_merge.sv
// fb_nibble_merge: replaces the covered pixel nibbles of a framebuffer byte with the fill colour.
module fb_nibble_merge import fb_pkg::*; (
    input  logic [7:0] rd,
    input  logic [3:0] color,
    input  logic       hi,
    input  logic       lo,
    output logic [7:0] wdata
);
    logic up, dn;
    always_comb begin
        up = EVEN_HI ? hi : lo;
        dn = EVEN_HI ? lo : hi;
        wdata = {up ? color : rd[7:4], dn ? color : rd[3:0]};
    end
endmodule

// File: rtl/fb_fill.sv
// fb_fill: rectangle fill into the packed 4-bpp framebuffer; full bytes written directly, edge bytes by read-modify-write.
// Optional screen clipping when FB_FILL_CLIP_EN is defined.
module fb_fill import fb_pkg::*; (
    input logic      clock_50,
    input logic      reset,
    fb_fill_if.slave bus
);
    fb_state_t          state_q, state_d;
    logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d, row_q, row_d;
    logic [3:0]         c_q, c_d;
    logic [ADDR_W-1:0]  base_q, base_d, mem_address_q, mem_address_d;
    logic [BX_W-1:0]    bx_q, bx_d;
    logic               hi_q, hi_d, lo_q, lo_d, adv, empty;
    logic [7:0]         mem_wdata_q, mem_wdata_d, merged;
    logic               mem_we_q, mem_we_d, cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d, done_q, done_d;

    fb_nibble_merge u_merge (.rd(bus.mem_rdata), .color(c_q), .hi(hi_d), .lo(lo_d), .wdata(merged));

    always_comb begin
        state_d = state_q;
        x0_d = x0_q;
        x1_d = x1_q;
        y1_d = y1_q;
        c_d = c_q;
        row_d = row_q;
        base_d = base_q;
        bx_d = bx_q;
        adv = 1'b0;
        empty = 1'b0;
        case (state_q)
            S_IDLE: if (bus.cmd_valid && cmd_ready_q) begin
                x0_d = bus.cmd_x0;
                x1_d = bus.cmd_x1;
                row_d = bus.cmd_y0;
                y1_d = bus.cmd_y1;
                c_d = bus.cmd_color;
                state_d = S_SETUP;
            end
            S_SETUP: begin
`ifdef FB_FILL_CLIP_EN
                x1_d = (x1_q > COORD_W'(WIDTH - 1)) ? COORD_W'(WIDTH - 1) : x1_q;
                y1_d = (y1_q > COORD_W'(HEIGHT - 1)) ? COORD_W'(HEIGHT - 1) : y1_q;
                empty = x0_q >= COORD_W'(WIDTH) || row_q >= COORD_W'(HEIGHT) || x0_q > x1_d || row_q > y1_d;
`else
                empty = x0_q > x1_q || row_q > y1_q;
`endif
                base_d = ADDR_W'(row_q) * ADDR_W'(STRIDE);
                bx_d = x0_q[COORD_W-1:1];
                state_d = empty ? S_DONE : S_SPAN;
            end
            S_SPAN: begin
                adv = hi_q && lo_q;
                state_d = adv ? S_SPAN : S_READ;
            end
            S_READ:  state_d = S_MERGE;
            S_MERGE: adv = 1'b1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Row step reuses the running base so only SETUP needs the multiply.
        if (adv) begin
            if (bx_q < x1_q[COORD_W-1:1]) begin
                bx_d = bx_q + 1'b1;
                state_d = S_SPAN;
            end else if (row_q == y1_q) begin
                state_d = S_DONE;
            end else begin
                row_d = row_q + 1'b1;
                base_d = base_q + ADDR_W'(STRIDE);
                bx_d = x0_q[COORD_W-1:1];
                state_d = S_SPAN;
            end
        end
    end

    // Outputs are computed for the state being entered so they are registered yet aligned with it.
    always_comb begin
        hi_d = {bx_d, 1'b0} >= x0_d;
        lo_d = {bx_d, 1'b1} <= x1_d;
        mem_we_d = (state_d == S_SPAN && hi_d && lo_d) || state_d == S_MERGE;
        mem_address_d = (state_d inside {S_SPAN, S_READ, S_MERGE}) ? base_d + ADDR_W'(bx_d) : mem_address_q;
        mem_wdata_d = mem_we_d ? merged : mem_wdata_q;
        cmd_ready_d = state_d == S_IDLE;
        busy_d = !cmd_ready_d;
        done_d = state_d == S_DONE;
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            c_q <= '0;
            row_q <= '0;
            base_q <= '0;
            bx_q <= '0;
            hi_q <= 1'b0;
            lo_q <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q <= '0;
            mem_we_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q <= x0_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
            c_q <= c_d;
            row_q <= row_d;
            base_q <= base_d;
            bx_q <= bx_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q <= mem_we_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_fb_fill.sv
// tb_fb_fill: scoreboard bench for fb_fill with a behavioural synchronous RAM on the write port.
module tb_fb_fill;
    localparam int BUDGET = 4000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_fill_if bus();
    fb_fill dut (.clock_50(clk), .reset(rst), .bus(bus));

    logic [7:0]  ram [0:262143];
    logic [7:0]  mdl [0:262143];
    logic        clr = 1'b1;
    logic        pre_en = 1'b0;
    logic [17:0] pre_a = '0;
    logic [7:0]  pre_d = '0;
    logic [25:0] sb [$];
    logic [25:0] exp_w;
    int total = 0;
    int bad = 0;

    always @(posedge clk) begin
        if (clr) for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
        else if (pre_en) ram[pre_a] <= pre_d;
        else if (bus.mem_we) ram[bus.mem_address] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_address];
    end

    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected addr=%0d data=%h required=none", bus.mem_address, bus.mem_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({bus.mem_address, bus.mem_wdata} !== exp_w) begin
                    bad++;
                    $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                             bus.mem_address, bus.mem_wdata, exp_w[25:8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic model(input logic [9:0] x0, x1, y0, y1, input logic [3:0] c, output int dc, output int nw);
        logic [9:0] ex1, ey1;
        logic emp, h, l;
        logic [17:0] a;
        logic [7:0] v;
        ex1 = x1;
        ey1 = y1;
        emp = (x0 > x1) || (y0 > y1);
`ifdef FB_FILL_CLIP_EN
        if (x1 > 10'd639) ex1 = 10'd639;
        if (y1 > 10'd399) ey1 = 10'd399;
        emp = (x0 >= 10'd640) || (y0 >= 10'd400) || (x0 > ex1) || (y0 > ey1);
`endif
        dc = 2;
        nw = 0;
        if (!emp) for (int y = int'(y0); y <= int'(ey1); y++) begin
            for (int b = int'(x0) / 2; b <= int'(ex1) / 2; b++) begin
                h = (2 * b >= int'(x0));
                l = (2 * b + 1 <= int'(ex1));
                a = 18'(y * 320 + b);
                v = mdl[a];
                if (h) v[7:4] = c;
                if (l) v[3:0] = c;
                mdl[a] = v;
                sb.push_back({a, v});
                nw++;
                dc += (h && l) ? 1 : 3;
            end
        end
    endtask

    task automatic issue(input logic [9:0] x0, x1, y0, y1, input logic [3:0] c);
        @(negedge clk);
        bus.cmd_x0 = x0;
        bus.cmd_x1 = x1;
        bus.cmd_y0 = y0;
        bus.cmd_y1 = y1;
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int k, output int nw, output int fw, output int lw, output logic [17:0] la);
        k = 0; nw = 0; fw = 0; lw = 0; la = '0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                nw++;
                if (fw == 0) fw = i;
                lw = i;
                la = bus.mem_address;
            end
            if (bus.done) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout waited=%0d cycles required=done pulse", BUDGET);
        end
    endtask

    task automatic run_cmd(input logic [9:0] x0, x1, y0, y1, input logic [3:0] c,
                           output int fw, output int lw, output logic [17:0] la);
        int edc, enw, dc, nw;
        model(x0, x1, y0, y1, c, edc, enw);
        issue(x0, x1, y0, y1, c);
        wait_done(dc, nw, fw, lw, la);
        total += 3;
        if (dc !== edc) begin bad++; $display("FAIL done_latency x0=%0d y0=%0d got=%0d required=%0d", x0, y0, dc, edc); end
        if (nw !== enw) begin bad++; $display("FAIL write_count x0=%0d y0=%0d got=%0d required=%0d", x0, y0, nw, enw); end
        if (sb.size() != 0) begin bad++; $display("FAIL missing_writes got=%0d pending required=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total += 6;
        if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b required=1", bus.cmd_ready); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b required=0", bus.done); end
        if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b required=0", bus.mem_we); end
        if (bus.mem_address !== 18'd0) begin bad++; $display("FAIL rst_addr got=%0d required=0", bus.mem_address); end
        if (bus.mem_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata got=%h required=00", bus.mem_wdata); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready got=%b required=1", bus.cmd_ready); end
    endtask

    task automatic test_pixel;
        int edc, enw;
        logic [6:1] we_e, dn_e;
        we_e = 6'b001000;
        dn_e = 6'b010000;
        mdl[2] = 8'h3C;
        @(negedge clk);
        pre_a = 18'd2; pre_d = 8'h3C; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        model(10'd5, 10'd5, 10'd0, 10'd0, 4'hA, edc, enw);
        issue(10'd5, 10'd5, 10'd0, 10'd0, 4'hA);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total += 2;
            if (bus.mem_we !== we_e[k]) begin bad++; $display("FAIL pixel_we C%0d got=%b required=%b", k, bus.mem_we, we_e[k]); end
            if (bus.done !== dn_e[k]) begin bad++; $display("FAIL pixel_done C%0d got=%b required=%b", k, bus.done, dn_e[k]); end
            if (k >= 2 && k <= 4) begin
                total++;
                if (bus.mem_address !== 18'd2) begin bad++; $display("FAIL pixel_addr C%0d got=%0d required=2", k, bus.mem_address); end
            end
            if (k == 1) begin
                total++;
                if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL pixel_busy busy=%b ready=%b required busy=1 ready=0", bus.busy, bus.cmd_ready); end
            end
        end
        total++;
        if (sb.size() != 0 || enw != 1 || edc != 5) begin bad++; $display("FAIL pixel_pending got=%0d required=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_full_span;
        int fw, lw;
        logic [17:0] la;
        run_cmd(10'd0, 10'd3, 10'd10, 10'd10, 4'h7, fw, lw, la);
        total += 2;
        if (fw !== 2 || lw !== 3) begin bad++; $display("FAIL span_cycles first=%0d last=%0d required first=2 last=3", fw, lw); end
        if (la !== 18'd3201) begin bad++; $display("FAIL span_last_addr got=%0d required=3201", la); end
    endtask

    task automatic test_edges;
        int fw, lw;
        logic [17:0] la;
        run_cmd(10'd1, 10'd2, 10'd1, 10'd2, 4'hF, fw, lw, la);
        total++;
        if (la !== 18'd641) begin bad++; $display("FAIL edge_last_addr got=%0d required=641", la); end
    endtask

    task automatic test_empty;
        int fw, lw;
        logic [17:0] la;
        run_cmd(10'd5, 10'd4, 10'd0, 10'd0, 4'h1, fw, lw, la);
        run_cmd(10'd0, 10'd0, 10'd3, 10'd2, 4'h1, fw, lw, la);
    endtask

    task automatic test_back_to_back;
        int eda, enwa, edb, enwb, da, acc, db, nw, fw, lw;
        logic [17:0] la;
        model(10'd3, 10'd10, 10'd20, 10'd21, 4'h5, eda, enwa);
        model(10'd0, 10'd0, 10'd30, 10'd30, 4'h6, edb, enwb);
        issue(10'd3, 10'd10, 10'd20, 10'd21, 4'h5);
        bus.cmd_x0 = 10'd0; bus.cmd_x1 = 10'd0; bus.cmd_y0 = 10'd30; bus.cmd_y1 = 10'd30;
        bus.cmd_color = 4'h6; bus.cmd_valid = 1'b1;
        da = 0; acc = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            if (bus.done) da = i;
            if (bus.cmd_ready) begin
                acc = i;
                @(posedge clk);
                #1 bus.cmd_valid = 1'b0;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        total += 2;
        if (da !== eda) begin bad++; $display("FAIL b2b_first_done got=%0d required=%0d", da, eda); end
        if (acc !== eda + 1) begin bad++; $display("FAIL b2b_accept got=%0d required=%0d", acc, eda + 1); end
        wait_done(db, nw, fw, lw, la);
        total += 2;
        if (db !== edb) begin bad++; $display("FAIL b2b_second_done got=%0d required=%0d", db, edb); end
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d required=0", sb.size()); sb.delete(); end
    endtask

`ifdef FB_FILL_CLIP_EN
    task automatic test_clip;
        int fw, lw;
        logic [17:0] la;
        run_cmd(10'd630, 10'd700, 10'd0, 10'd0, 4'h3, fw, lw, la);
        total++;
        if (la !== 18'd319) begin bad++; $display("FAIL clip_last_addr got=%0d required=319", la); end
        run_cmd(10'd640, 10'd650, 10'd0, 10'd0, 4'h3, fw, lw, la);
        run_cmd(10'd0, 10'd1, 10'd399, 10'd500, 4'h5, fw, lw, la);
        total++;
        if (la !== 18'd127680) begin bad++; $display("FAIL clip_y_addr got=%0d required=127680", la); end
    endtask
`else
    task automatic test_clip;
        int fw, lw;
        logic [17:0] la;
        run_cmd(10'd0, 10'd1, 10'd1000, 10'd1000, 4'h4, fw, lw, la);
        total++;
        if (la !== 18'd57856) begin bad++; $display("FAIL wrap_addr got=%0d required=57856", la); end
        run_cmd(10'd1022, 10'd1023, 10'd0, 10'd0, 4'h4, fw, lw, la);
        total++;
        if (la !== 18'd511) begin bad++; $display("FAIL wide_addr got=%0d required=511", la); end
    endtask
`endif

    task automatic test_reset_mid;
        int edc, enw, fw, lw;
        logic [17:0] la;
        model(10'd0, 10'd639, 10'd0, 10'd9, 4'h2, edc, enw);
        issue(10'd0, 10'd639, 10'd0, 10'd9, 4'h2);
        repeat (30) @(negedge clk);
        total++;
        if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL mid_fill_we got=%b required=1", bus.mem_we); end
        #1 rst = 1'b1;
        #1;
        total += 2;
        if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL async_we got=%b required=0", bus.mem_we); end
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL async_state busy=%b ready=%b required busy=0 ready=1", bus.busy, bus.cmd_ready); end
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL post_rst ready=%b busy=%b required ready=1 busy=0", bus.cmd_ready, bus.busy); end
        run_cmd(10'd7, 10'd7, 10'd50, 10'd50, 4'h9, fw, lw, la);
        total++;
        if (la !== 18'd16003 || fw !== 4) begin bad++; $display("FAIL post_rst_pixel addr=%0d cycle=%0d required addr=16003 cycle=4", la, fw); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0; bus.cmd_x1 = '0; bus.cmd_y0 = '0; bus.cmd_y1 = '0; bus.cmd_color = '0;
        for (int i = 0; i < 262144; i++) mdl[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        test_reset;
        test_pixel;
        test_full_span;
        test_edges;
        test_empty;
        test_back_to_back;
        test_clip;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
